// File: rtl/pc_chk_pkg.sv
// Shared types and constants for the program-counter stream checker.
package pc_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int GOOD_CNT_W = 8;

    // All-ones value for a counter of width w (w up to 64).
    function automatic logic [63:0] sat_max(input int unsigned w);
        if (w >= 32'd64) begin
            sat_max = {64{1'b1}};
        end else begin
            sat_max = (64'd1 << w) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/pc_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds once it reaches all ones.
module sat_counter
    import pc_chk_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    logic [W-1:0] r_count;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pc_checker.sv
// Checks that a sampled pc stream increments by one; locks after a run of
// good increments and reports every break while locked.
module pc_checker
    import pc_chk_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             clr,
    input  logic             pc_valid,
    input  logic [WIDTH-1:0] pc,
    output logic             locked,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_pc,
    output logic [WIDTH-1:0] bad_pc
);

    localparam logic [GOOD_CNT_W-1:0] LC_LAST = GOOD_CNT_W'(LOCK_COUNT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [GOOD_CNT_W-1:0] r_good_cnt;
    logic [GOOD_CNT_W-1:0] w_good_cnt_nxt;
    logic                  r_locked;
    logic                  r_mismatch;
    logic [WIDTH-1:0]      r_exp_pc;
    logic [WIDTH-1:0]      r_bad_pc;
    logic                  w_match;
    logic                  w_sample;
    logic                  w_mismatch_nxt;
    logic                  w_locked_nxt;

    assign w_match  = (pc == r_exp_pc);
    assign w_sample = pc_valid & ~clr;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = IDLE;
        end else if (pc_valid) begin
            case (r_state)
                IDLE:    w_next_state = SYNC;
                SYNC:    w_next_state = (w_match && (r_good_cnt == LC_LAST)) ? LOCKED : SYNC;
                LOCKED:  w_next_state = w_match ? LOCKED : SYNC;
                default: w_next_state = IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Acquisition counter restarts on entry to SYNC and on any break.
    always_comb begin
        w_good_cnt_nxt = r_good_cnt;
        w_mismatch_nxt = 1'b0;
        w_locked_nxt   = (w_next_state == LOCKED);
        if (clr) begin
            w_good_cnt_nxt = '0;
        end else if (pc_valid) begin
            case (r_state)
                IDLE: w_good_cnt_nxt = '0;
                SYNC: begin
                    if (w_match && (r_good_cnt != LC_LAST)) begin
                        w_good_cnt_nxt = r_good_cnt + 8'd1;
                    end else begin
                        w_good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_good_cnt_nxt = r_good_cnt;
                    end else begin
                        w_good_cnt_nxt = '0;
                        w_mismatch_nxt = 1'b1;
                    end
                end
                default: w_good_cnt_nxt = '0;
            endcase
        end else begin
            w_good_cnt_nxt = r_good_cnt;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_exp_pc   <= '0;
            r_bad_pc   <= '0;
        end else begin
            r_good_cnt <= w_good_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_mismatch <= w_mismatch_nxt;
            if (w_sample) begin
                r_exp_pc <= pc + WIDTH'(1);
            end
            if (w_mismatch_nxt) begin
                r_bad_pc <= pc;
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clkin(clkin),
        .rst  (rst),
        .clr  (clr),
        .inc  (w_mismatch_nxt),
        .count(err_count)
    );

    assign locked   = r_locked;
    assign mismatch = r_mismatch;
    assign exp_pc   = r_exp_pc;
    assign bad_pc   = r_bad_pc;

endmodule

// File: tb/tb_pc_checker.sv
// Directed scoreboard bench for pc_checker (WIDTH=32, LOCK_COUNT=4, ERR_W=2).
module tb_pc_checker;

    logic        clkin;
    logic        rst;
    logic        clr;
    logic        pc_valid;
    logic [31:0] pc;
    logic        locked;
    logic        mismatch;
    logic [1:0]  err_count;
    logic [31:0] exp_pc;
    logic [31:0] bad_pc;

    typedef struct {
        logic        lk;
        logic        mm;
        logic [1:0]  err;
        logic [31:0] epc;
        logic [31:0] bpc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    pc_checker #(
        .WIDTH     (32),
        .LOCK_COUNT(4),
        .ERR_W     (2)
    ) dut (
        .clkin    (clkin),
        .rst      (rst),
        .clr      (clr),
        .pc_valid (pc_valid),
        .pc       (pc),
        .locked   (locked),
        .mismatch (mismatch),
        .err_count(err_count),
        .exp_pc   (exp_pc),
        .bad_pc   (bad_pc)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (act !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, want);
        end
    endtask

    // Monitor: reset values while rst is high, otherwise pop one expectation per cycle.
    always @(negedge clkin or posedge rst) begin
        if (rst) begin
            #1;
            chk("rst_locked", {31'd0, locked}, 32'd0);
            chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
            chk("rst_err_count", {30'd0, err_count}, 32'd0);
            chk("rst_exp_pc", exp_pc, 32'd0);
            chk("rst_bad_pc", bad_pc, 32'd0);
        end else if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("locked", {31'd0, locked}, {31'd0, e.lk});
            chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
            chk("err_count", {30'd0, err_count}, {30'd0, e.err});
            chk("exp_pc", exp_pc, e.epc);
            chk("bad_pc", bad_pc, e.bpc);
        end
    end

    task automatic step(input logic v, input logic c, input logic [31:0] p,
                        input logic lk, input logic mm, input logic [1:0] err,
                        input logic [31:0] epc, input logic [31:0] bpc);
        exp_t e;
        pc_valid = v;
        clr      = c;
        pc       = p;
        @(posedge clkin);
        e.lk  = lk;
        e.mm  = mm;
        e.err = err;
        e.epc = epc;
        e.bpc = bpc;
        q.push_back(e);
        @(negedge clkin);
    endtask

    initial begin
        logic [31:0] b;
        logic [1:0]  e;
        rst      = 1'b0;
        clr      = 1'b0;
        pc_valid = 1'b0;
        pc       = 32'd0;
        #1 rst = 1'b1;
        @(negedge clkin);
        @(negedge clkin);
        #2 rst = 1'b0;

        // lock acquisition
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0);
        step(1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 2'd0, 32'd2, 32'd0);
        step(1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 2'd0, 32'd3, 32'd0);
        step(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 2'd0, 32'd4, 32'd0);
        step(1'b1, 1'b0, 32'd4, 1'b1, 1'b0, 2'd0, 32'd5, 32'd0);

        // clear, then lock across the wrap
        step(1'b0, 1'b1, 32'd99, 1'b0, 1'b0, 2'd0, 32'd5, 32'd0);
        step(1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'd0);
        step(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd1, 32'd0);
        step(1'b1, 1'b0, 32'd1, 1'b1, 1'b0, 2'd0, 32'd2, 32'd0);
        for (int p = 2; p <= 9; p++) begin
            step(1'b1, 1'b0, 32'(p), 1'b1, 1'b0, 2'd0, 32'(p + 1), 32'd0);
        end

        // break while locked at exp_pc=10, then relock on 21..24
        step(1'b1, 1'b0, 32'd20, 1'b0, 1'b1, 2'd1, 32'd21, 32'd20);
        step(1'b0, 1'b0, 32'd77, 1'b0, 1'b0, 2'd1, 32'd21, 32'd20);
        step(1'b1, 1'b0, 32'd21, 1'b0, 1'b0, 2'd1, 32'd22, 32'd20);
        step(1'b1, 1'b0, 32'd22, 1'b0, 1'b0, 2'd1, 32'd23, 32'd20);
        step(1'b1, 1'b0, 32'd23, 1'b0, 1'b0, 2'd1, 32'd24, 32'd20);
        step(1'b1, 1'b0, 32'd24, 1'b1, 1'b0, 2'd1, 32'd25, 32'd20);

        // valid gaps and an acquisition error in SYNC
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 2'd0, 32'd25, 32'd20);
        step(1'b1, 1'b0, 32'd4, 1'b0, 1'b0, 2'd0, 32'd5, 32'd20);
        step(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 2'd0, 32'd6, 32'd20);
        step(1'b0, 1'b0, 32'd55, 1'b0, 1'b0, 2'd0, 32'd6, 32'd20);
        step(1'b1, 1'b0, 32'd6, 1'b0, 1'b0, 2'd0, 32'd7, 32'd20);
        step(1'b0, 1'b0, 32'd56, 1'b0, 1'b0, 2'd0, 32'd7, 32'd20);
        step(1'b1, 1'b0, 32'd8, 1'b0, 1'b0, 2'd0, 32'd9, 32'd20);
        for (int p = 9; p <= 11; p++) begin
            step(1'b1, 1'b0, 32'(p), 1'b0, 1'b0, 2'd0, 32'(p + 1), 32'd20);
        end
        step(1'b1, 1'b0, 32'd12, 1'b1, 1'b0, 2'd0, 32'd13, 32'd20);

        // two breaks to reach err_count=2, then clr with a valid sample
        step(1'b1, 1'b0, 32'd50, 1'b0, 1'b1, 2'd1, 32'd51, 32'd50);
        for (int p = 51; p <= 53; p++) begin
            step(1'b1, 1'b0, 32'(p), 1'b0, 1'b0, 2'd1, 32'(p + 1), 32'd50);
        end
        step(1'b1, 1'b0, 32'd54, 1'b1, 1'b0, 2'd1, 32'd55, 32'd50);
        step(1'b1, 1'b0, 32'd60, 1'b0, 1'b1, 2'd2, 32'd61, 32'd60);
        for (int p = 61; p <= 63; p++) begin
            step(1'b1, 1'b0, 32'(p), 1'b0, 1'b0, 2'd2, 32'(p + 1), 32'd60);
        end
        step(1'b1, 1'b0, 32'd64, 1'b1, 1'b0, 2'd2, 32'd65, 32'd60);
        step(1'b1, 1'b1, 32'd65, 1'b0, 1'b0, 2'd0, 32'd65, 32'd60);
        step(1'b1, 1'b0, 32'd70, 1'b0, 1'b0, 2'd0, 32'd71, 32'd60);
        for (int p = 71; p <= 73; p++) begin
            step(1'b1, 1'b0, 32'(p), 1'b0, 1'b0, 2'd0, 32'(p + 1), 32'd60);
        end
        step(1'b1, 1'b0, 32'd74, 1'b1, 1'b0, 2'd0, 32'd75, 32'd60);

        // five breaks with a 2-bit error counter: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            b = 32'(100 * (i + 1));
            e = (i >= 2) ? 2'd3 : 2'(i + 1);
            step(1'b1, 1'b0, b, 1'b0, 1'b1, e, b + 32'd1, b);
            for (int k = 1; k <= 3; k++) begin
                step(1'b1, 1'b0, b + 32'(k), 1'b0, 1'b0, e, b + 32'(k + 1), b);
            end
            step(1'b1, 1'b0, b + 32'd4, 1'b1, 1'b0, e, b + 32'd5, b);
        end

        // asynchronous reset between edges
        pc_valid = 1'b0;
        #3 rst = 1'b1;
        #10;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
